mod_reduce_pipe: RTL
====================

Name: mod_reduce_pipe

Overview:
- Final-reduction stage that sits directly downstream of the 378-bit pipelined modular adder.
- Takes the raw sum S, which is WIDTH+1 bits and satisfies S < 2*MODULUS.
- Returns S mod MODULUS, using a segmented borrow-chain subtract of MODULUS followed by a select.
- Carries its own valid/ready handshake with per-stage stall, so it can feed the point-add datapath under backpressure.

Parameters:
- WIDTH, 377: field element width in bits; the input is WIDTH+1 bits.
- SEGMENTS, 9: number of subtract pipeline segments; one borrow hop per stage.
- MODULUS, BLS12-377 base-field prime 0x01ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001: value subtracted.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: sum_i is valid this cycle.
- in_ready, output, 1: stage 1 can accept this cycle.
- sum_i, input, WIDTH+1: raw adder sum, required < 2*MODULUS.
- out_valid, output, 1: res_o is valid.
- out_ready, input, 1: consumer accepts res_o.
- res_o, output, WIDTH: reduced result.
- idle, output, 1: high when no stage holds valid data.

Behaviour:
- Segmentation
  - SEG = ceil((WIDTH+1)/SEGMENTS); operands are zero-extended to SEGMENTS*SEG bits.
  - MODULUS is likewise split into constant segments.
- Pipeline
  - SEGMENTS subtract stages P1..P_SEGMENTS, then one output register stage PO; total SEGMENTS+1 register stages.
  - Stage k computes diff[k] = sum[k] - mod[k] - borrow_in, with borrow_in = 0 for k = 1.
  - It registers the diff segment, borrow_out, all earlier diff segments, and the full original sum.
  - PO selects: if final borrow = 0 (S >= MODULUS), res_o = diff[WIDTH-1:0]; else res_o = S[WIDTH-1:0].
- Latency: exactly SEGMENTS+1 cycles from the accept edge (in_valid & in_ready) to out_valid, when out_ready is held high. Full throughput: one result per cycle.
- Handshake
  - Each stage has stage_ready = !valid_k | ready_{k+1}, and ready past PO = out_ready; in_ready = stage_ready of stage 1.
  - A stage loads data and valid only when its stage_ready is high. Otherwise it holds data and valid unchanged.
  - The data registers of a stage holding valid=0 may load anything.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
  - in_ready is combinational from out_ready through the chain; no registered skid.
  - res_o and out_valid are stable while out_valid & !out_ready. A transfer occurs only on out_valid & out_ready.
- Capacity: SEGMENTS+1 entries. When full and out_ready is low, in_ready = 0.
- Reset
  - All valid bits clear, so out_valid = 0, in_ready = 1 and idle = 1 in the cycle after reset.
  - Data registers are not reset; res_o is don't-care while out_valid = 0.
  - Reset asserted mid-stream discards all in-flight entries. Nothing emerges after reset deasserts unless new input is accepted.
  - An input presented in the same cycle as rst is dropped.
- Simultaneous events: accept and emit in the same cycle are allowed; occupancy is unchanged.
- idle = !(valid of every stage); it does not include in_valid.
- Out-of-contract input (S >= 2*MODULUS): result is S - MODULUS truncated to WIDTH bits. There is no error flag.
- Order is preserved: strict FIFO order, no reordering, no drop, no duplication.

Test Plan:
- Boundary values with out_ready = 1, each checked on out_valid exactly 10 cycles after accept:
  - sum_i = 0 -> res_o = 0.
  - sum_i = MODULUS -> res_o = 0.
  - sum_i = MODULUS-1 -> res_o = MODULUS-1.
  - sum_i = 2*MODULUS-2 -> res_o = MODULUS-2.
- Borrow ripple: sum_i = MODULUS + 2^(SEG*8) - 1, which forces borrows across every segment boundary -> res_o = 2^(SEG*8) - 1.
- Throughput: 1000 back-to-back random S < 2P with out_ready = 1 -> 1000 outputs on consecutive cycles, each equal to the golden S mod P; in_ready never drops.
- Backpressure:
  - Stream 15 entries while out_ready = 0 for 30 cycles -> in_ready falls after exactly 10 accepts, and res_o stays stable.
  - Release out_ready -> all 15 results emerge in order, none lost.
- Random stall: in_valid and out_ready each toggled randomly at 50% -> scoreboard match; out_valid/res_o never change while stalled.
- Reset mid-stream: assert rst for 1 cycle with 6 entries in flight -> out_valid = 0 and idle = 1 next cycle; no stale results appear over the following 20 cycles.

Source files
------------

// File: rtl/mod_reduce_pipe.sv
// Final modular reduction: S (< 2*MODULUS) -> S mod MODULUS through a segmented
// borrow-chain subtract pipeline with per-stage valid/ready stall.
module mod_reduce_pipe #(
  parameter int               WIDTH    = 377,
  parameter int               SEGMENTS = 9,
  parameter logic [WIDTH-1:0] MODULUS  = 377'h1ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_o,
  output logic             idle
);

  localparam int SEG = (WIDTH + SEGMENTS) / SEGMENTS;
  localparam int TOT = SEG * SEGMENTS;
  localparam logic [TOT-1:0] MOD_EXT = TOT'(MODULUS);

  // Bit SEGMENTS of vld_p is the output register stage; lower bits are subtract stages.
  logic [SEGMENTS:0]   vld_p;
  logic [SEGMENTS:0]   vld_in;
  logic [SEGMENTS:0]   stage_rdy;
  logic [TOT-1:0]      sum_p    [SEGMENTS];
  logic [TOT-1:0]      diff_p   [SEGMENTS];
  logic [SEGMENTS-1:0] brw_p;
  logic [WIDTH-1:0]    res_po;

  logic [TOT-1:0]      sum_nxt  [SEGMENTS];
  logic [TOT-1:0]      diff_nxt [SEGMENTS];
  logic [SEG:0]        seg_r    [SEGMENTS];
  logic [SEGMENTS-1:0] brw_nxt;

  // One segment of the borrow chain: {borrow_out, diff}.
  function automatic logic [SEG:0] sub_seg(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           bin);
    return {1'b0, a} - {1'b0, b} - {{SEG{1'b0}}, bin};
  endfunction

  // Final borrow set means S < MODULUS, so the original sum is already reduced.
  function automatic logic [WIDTH-1:0] select_res(input logic [TOT-1:0] s,
                                                  input logic [TOT-1:0] d,
                                                  input logic           b);
    return b ? s[WIDTH-1:0] : d[WIDTH-1:0];
  endfunction

  // A stage may load whenever any stage at or after it is empty, or the sink drains.
  for (genvar k = 0; k <= SEGMENTS; k++) begin : g_rdy
    assign stage_rdy[k] = out_ready | ~(&vld_p[SEGMENTS:k]);
  end

  assign vld_in = {vld_p[SEGMENTS-1:0], in_valid};

  always_comb begin
    sum_nxt[0]  = TOT'(sum_i);
    seg_r[0]    = sub_seg(sum_nxt[0][SEG-1:0], MOD_EXT[SEG-1:0], 1'b0);
    diff_nxt[0] = '0;
    diff_nxt[0][SEG-1:0] = seg_r[0][SEG-1:0];
    brw_nxt[0]  = seg_r[0][SEG];
    for (int k = 1; k < SEGMENTS; k++) begin
      sum_nxt[k]  = sum_p[k-1];
      seg_r[k]    = sub_seg(sum_p[k-1][k*SEG +: SEG], MOD_EXT[k*SEG +: SEG], brw_p[k-1]);
      diff_nxt[k] = diff_p[k-1];
      diff_nxt[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
      brw_nxt[k]  = seg_r[k][SEG];
    end
  end

  // Stage boundary: subtract stages P1..P_SEGMENTS and output stage PO (data, no reset)
  always_ff @(posedge clk) begin
    for (int k = 0; k < SEGMENTS; k++) begin
      if (stage_rdy[k]) begin
        sum_p[k]  <= sum_nxt[k];
        diff_p[k] <= diff_nxt[k];
        brw_p[k]  <= brw_nxt[k];
      end
    end
    if (stage_rdy[SEGMENTS]) begin
      res_po <= select_res(sum_p[SEGMENTS-1], diff_p[SEGMENTS-1], brw_p[SEGMENTS-1]);
    end
  end

  // Stage boundary: valid bits for every stage (control, reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      for (int k = 0; k <= SEGMENTS; k++) begin
        if (stage_rdy[k]) vld_p[k] <= vld_in[k];
      end
    end
  end

  assign in_ready  = stage_rdy[0];
  assign out_valid = vld_p[SEGMENTS];
  assign res_o     = res_po;
  assign idle      = ~(|vld_p);

endmodule
